// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
//  Module      : free_list
//  Description : Physical-register free list for a register-renaming core.
//                A circular buffer of DEPTH physical-register numbers (pd)
//                with three pointers:
//                  head      - next pd handed to rename (speculative)
//                  tail      - where retired old mappings are written back
//                  arch_head - head position as seen by committed state;
//                              a flush rolls head back to it.
//                Each pointer carries one wrap bit above the index. This
//                makes empty (head == tail) and full (tail - head == DEPTH)
//                easy to tell apart.
//
//  Ports       :
//    clk             in   clock, all state updates on rising edge
//    rst_n           in   asynchronous active-low reset
//    free_list_deq   in   rename takes the head pd this cycle
//    free_list_pd    out  pd at head (valid only when free_list_empty = 0)
//    free_list_empty out  no free pd available
//    commit_valid    in   retiring instruction returns commit_old_pd
//    commit_old_pd   in   previous mapping of the retiring rd
//    flush           in   mispredict recovery, head <- arch_head
//    free_count      out  number of free entries, 0..DEPTH
//
//  Revision    : 1.0  initial release
// ============================================================================
module free_list #(
    parameter  int PHYS_REGS = 64,
    // DEPTH must be a power of two so that the pointers wrap modulo
    // 2*DEPTH simply by overflowing.
    parameter  int DEPTH     = 32,
    localparam int PD_W      = $clog2(PHYS_REGS),
    localparam int PTR_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             free_list_deq,
    output logic [PD_W-1:0]  free_list_pd,
    output logic             free_list_empty,
    input  logic             commit_valid,
    input  logic [PD_W-1:0]  commit_old_pd,
    input  logic             flush,
    output logic [PTR_W-1:0] free_count
);

    localparam int IDX_W = PTR_W - 1;

    localparam logic [PTR_W-1:0] c_ptr_one   = PTR_W'(1);
    // tail starts one full lap ahead of head: index 0, wrap bit set.
    localparam logic [PTR_W-1:0] c_tail_init = PTR_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PD_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_arch_head;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_empty;
    logic             w_deq;
    logic [PTR_W-1:0] w_commit_inc;
    logic [PTR_W-1:0] w_head_nxt;
    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_tail_idx;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];

    // Empty is judged on registered state only. An entry enqueued this
    // cycle is not visible until the next one, so a deq on an empty list
    // is dropped rather than bypassing commit_old_pd straight through.
    assign w_empty = (r_head == r_tail);

    // A flush overrides any allocation made in the same cycle.
    assign w_deq = free_list_deq & ~w_empty & ~flush;

    assign w_commit_inc = {{(PTR_W-1){1'b0}}, commit_valid};

    // On flush, head returns to the committed position. A commit in the
    // same cycle has already consumed its allocation, so it is counted.
    always_comb begin
        w_head_nxt = r_head;
        if (flush) begin
            w_head_nxt = r_arch_head + w_commit_inc;
        end else if (w_deq) begin
            w_head_nxt = r_head + c_ptr_one;
        end
    end

    // ------------------------------------------------------------------
    // Pointer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head      <= '0;
            r_tail      <= c_tail_init;
            r_arch_head <= '0;
        end else begin
            r_head <= w_head_nxt;
            if (commit_valid) begin
                r_tail      <= r_tail + c_ptr_one;
                r_arch_head <= r_arch_head + c_ptr_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage. Reset fills the list with p(DEPTH)..p(2*DEPTH-1): the
    // physical registers not holding an initial architectural mapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= PD_W'(DEPTH + i);
            end
        end else if (commit_valid) begin
            r_mem[w_tail_idx] <= commit_old_pd;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all taken from registered state
    // ------------------------------------------------------------------
    assign free_list_pd    = r_mem[w_head_idx];
    assign free_list_empty = w_empty;
    assign free_count      = r_tail - r_head;

endmodule
`default_nettype wire
